// File: rtl/rv32i_defs.sv
// Shared RV32I control encodings, opcode values and the decoded control bundle.
package rv32i_defs;

  localparam int unsigned XLEN = 32;

  localparam logic [1:0] RS1_X   = 2'd0;
  localparam logic [1:0] RS1_RS1 = 2'd1;
  localparam logic [1:0] RS1_PC  = 2'd2;

  localparam logic [1:0] RS2_X   = 2'd0;
  localparam logic [1:0] RS2_RS2 = 2'd1;
  localparam logic [1:0] RS2_IMI = 2'd2;

  localparam logic [2:0] BR_X    = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BGE  = 3'd4;
  localparam logic [2:0] BR_BLTU = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;
  localparam logic [2:0] BR_JAL  = 3'd7;

  localparam logic [1:0] WB_X   = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;
  localparam logic [1:0] WB_PC  = 2'd3;

  localparam logic [2:0] MEM_LW  = 3'd0;
  localparam logic [2:0] MEM_LB  = 3'd1;
  localparam logic [2:0] MEM_LH  = 3'd2;
  localparam logic [2:0] MEM_LBU = 3'd3;
  localparam logic [2:0] MEM_LHU = 3'd4;
  localparam logic [2:0] MEM_SB  = 3'd5;
  localparam logic [2:0] MEM_SH  = 3'd6;
  localparam logic [2:0] MEM_SW  = 3'd7;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_AND  = 5'd2;
  localparam logic [4:0] ALU_OR   = 5'd3;
  localparam logic [4:0] ALU_XOR  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_SRL  = 5'd6;
  localparam logic [4:0] ALU_SRA  = 5'd7;
  localparam logic [4:0] ALU_SLT  = 5'd8;
  localparam logic [4:0] ALU_SLTU = 5'd9;
  localparam logic [4:0] ALU_JALR = 5'd10;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [31:0] INST_ECALL = 32'h0000_0073;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [4:0]      rd_addr;
    logic [4:0]      alu_fn;
    logic [1:0]      rs1_sel;
    logic [1:0]      rs2_sel;
    logic [2:0]      br;
    logic [2:0]      mem_fn;
    logic [1:0]      wb_sel;
  } ctrl_t;

endpackage

// File: rtl/rv32i_decode.sv
// Combinational RV32I decoder; anything not recognised decodes to the all-zero bubble.
module rv32i_decode
  import rv32i_defs::*;
(
  input  logic [31:0] inst,
  output ctrl_t       ctrl,
  output logic        ecall
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  always_comb begin
    ctrl  = '0;
    ecall = (inst == INST_ECALL);
    case (opcode)
      OPC_LUI: begin
        ctrl.imm = imm_u; ctrl.rd_addr = inst[11:7];
        ctrl.rs1_sel = RS1_X; ctrl.rs2_sel = RS2_IMI;
        ctrl.alu_fn = ALU_ADD; ctrl.wb_sel = WB_ALU;
      end
      OPC_AUIPC: begin
        ctrl.imm = imm_u; ctrl.rd_addr = inst[11:7];
        ctrl.rs1_sel = RS1_PC; ctrl.rs2_sel = RS2_IMI;
        ctrl.alu_fn = ALU_ADD; ctrl.wb_sel = WB_ALU;
      end
      OPC_JAL: begin
        ctrl.imm = imm_j; ctrl.rd_addr = inst[11:7];
        ctrl.rs1_sel = RS1_PC; ctrl.rs2_sel = RS2_IMI;
        ctrl.alu_fn = ALU_ADD; ctrl.br = BR_JAL; ctrl.wb_sel = WB_PC;
      end
      OPC_JALR: begin
        ctrl.imm = imm_i; ctrl.rd_addr = inst[11:7]; ctrl.rs1_addr = inst[19:15];
        ctrl.rs1_sel = RS1_RS1; ctrl.rs2_sel = RS2_IMI;
        ctrl.alu_fn = ALU_JALR; ctrl.br = BR_JAL; ctrl.wb_sel = WB_PC;
      end
      OPC_BRANCH: begin
        // funct3 010/011 are reserved and leave the bubble in place
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          ctrl.imm = imm_b; ctrl.rs1_addr = inst[19:15]; ctrl.rs2_addr = inst[24:20];
          ctrl.rs1_sel = RS1_PC; ctrl.rs2_sel = RS2_IMI;
          ctrl.alu_fn = ALU_ADD; ctrl.wb_sel = WB_X;
          case (funct3)
            3'b000:  ctrl.br = BR_BEQ;
            3'b001:  ctrl.br = BR_BNE;
            3'b100:  ctrl.br = BR_BLT;
            3'b101:  ctrl.br = BR_BGE;
            3'b110:  ctrl.br = BR_BLTU;
            default: ctrl.br = BR_BGEU;
          endcase
        end
      end
      OPC_LOAD: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
          ctrl.imm = imm_i; ctrl.rd_addr = inst[11:7]; ctrl.rs1_addr = inst[19:15];
          ctrl.rs1_sel = RS1_RS1; ctrl.rs2_sel = RS2_IMI;
          ctrl.alu_fn = ALU_ADD; ctrl.wb_sel = WB_MEM;
          case (funct3)
            3'b000:  ctrl.mem_fn = MEM_LB;
            3'b001:  ctrl.mem_fn = MEM_LH;
            3'b100:  ctrl.mem_fn = MEM_LBU;
            3'b101:  ctrl.mem_fn = MEM_LHU;
            default: ctrl.mem_fn = MEM_LW;
          endcase
        end
      end
      OPC_STORE: begin
        if (funct3 inside {3'b000, 3'b001, 3'b010}) begin
          ctrl.imm = imm_s; ctrl.rs1_addr = inst[19:15]; ctrl.rs2_addr = inst[24:20];
          ctrl.rs1_sel = RS1_RS1; ctrl.rs2_sel = RS2_IMI;
          ctrl.alu_fn = ALU_ADD; ctrl.wb_sel = WB_X;
          case (funct3)
            3'b000:  ctrl.mem_fn = MEM_SB;
            3'b001:  ctrl.mem_fn = MEM_SH;
            default: ctrl.mem_fn = MEM_SW;
          endcase
        end
      end
      OPC_OP_IMM, OPC_OP: begin
        ctrl.rd_addr = inst[11:7]; ctrl.rs1_addr = inst[19:15];
        ctrl.rs1_sel = RS1_RS1; ctrl.wb_sel = WB_ALU;
        if (opcode == OPC_OP) begin
          ctrl.rs2_addr = inst[24:20]; ctrl.rs2_sel = RS2_RS2;
        end else begin
          ctrl.imm = imm_i; ctrl.rs2_sel = RS2_IMI;
        end
        case (funct3)
          3'b000:  ctrl.alu_fn = (opcode == OPC_OP && inst[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl.alu_fn = ALU_SLL;
          3'b010:  ctrl.alu_fn = ALU_SLT;
          3'b011:  ctrl.alu_fn = ALU_SLTU;
          3'b100:  ctrl.alu_fn = ALU_XOR;
          3'b101:  ctrl.alu_fn = inst[30] ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl.alu_fn = ALU_OR;
          default: ctrl.alu_fn = ALU_AND;
        endcase
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/rv32i_exec_units.sv
// RV32I decoder, combinational ALU and byte-addressed little-endian data memory.
module rv32i_exec_units
  import rv32i_defs::*;
#(
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  output logic [31:0] imm,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [4:0]  alu_fn,
  output logic [1:0]  rs1_sel,
  output logic [1:0]  rs2_sel,
  output logic [2:0]  br,
  output logic [2:0]  mem_fn,
  output logic [1:0]  wb_sel,
  output logic        ecall,
  input  logic [4:0]  alu_op,
  input  logic [31:0] alu_src1,
  input  logic [31:0] alu_src2,
  output logic [31:0] alu_out,
  input  logic [2:0]  dmem_fn,
  input  logic [31:0] dmem_addr,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata
);

  localparam int unsigned AW = $clog2(4 * DMEM_WORDS);

  ctrl_t ctrl;

  rv32i_decode u_decode (
    .inst  (inst),
    .ctrl  (ctrl),
    .ecall (ecall)
  );

  assign imm      = ctrl.imm;
  assign rs1_addr = ctrl.rs1_addr;
  assign rs2_addr = ctrl.rs2_addr;
  assign rd_addr  = ctrl.rd_addr;
  assign alu_fn   = ctrl.alu_fn;
  assign rs1_sel  = ctrl.rs1_sel;
  assign rs2_sel  = ctrl.rs2_sel;
  assign br       = ctrl.br;
  assign mem_fn   = ctrl.mem_fn;
  assign wb_sel   = ctrl.wb_sel;

  // ALU
  logic [4:0]  shamt;
  logic [31:0] sum;
  assign shamt = alu_src2[4:0];
  assign sum   = alu_src1 + alu_src2;

  always_comb begin
    alu_out = '0;
    case (alu_op)
      ALU_ADD:  alu_out = sum;
      ALU_SUB:  alu_out = alu_src1 - alu_src2;
      ALU_AND:  alu_out = alu_src1 & alu_src2;
      ALU_OR:   alu_out = alu_src1 | alu_src2;
      ALU_XOR:  alu_out = alu_src1 ^ alu_src2;
      ALU_SLL:  alu_out = alu_src1 << shamt;
      ALU_SRL:  alu_out = alu_src1 >> shamt;
      ALU_SRA:  alu_out = 32'($signed(alu_src1) >>> shamt);
      ALU_SLT:  alu_out = {31'b0, $signed(alu_src1) < $signed(alu_src2)};
      ALU_SLTU: alu_out = {31'b0, alu_src1 < alu_src2};
      ALU_JALR: alu_out = sum & ~32'h1;
      default:  alu_out = '0;
    endcase
  end

  // Data memory: upper address bits beyond the array simply alias
  logic [31:0]   mem [DMEM_WORDS];
  logic [AW-3:0] widx;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [3:0]    be;
  logic [31:0]   wd;
  logic          unused_addr;

  assign unused_addr = ^dmem_addr[31:AW];
  assign widx  = dmem_addr[AW-1:2];
  assign rword = mem[widx];
  assign rbyte = rword[8*dmem_addr[1:0] +: 8];
  assign rhalf = dmem_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    dmem_rdata = rword;
    case (dmem_fn)
      MEM_LB:  dmem_rdata = {{24{rbyte[7]}}, rbyte};
      MEM_LBU: dmem_rdata = {24'b0, rbyte};
      MEM_LH:  dmem_rdata = {{16{rhalf[15]}}, rhalf};
      MEM_LHU: dmem_rdata = {16'b0, rhalf};
      default: dmem_rdata = rword;
    endcase
  end

  // Lane enables and lane-replicated write data for stores
  always_comb begin
    be = 4'b0000;
    wd = dmem_wdata;
    case (dmem_fn)
      MEM_SB: begin be = 4'(4'b0001 << dmem_addr[1:0]); wd = {4{dmem_wdata[7:0]}}; end
      MEM_SH: begin be = dmem_addr[1] ? 4'b1100 : 4'b0011; wd = {2{dmem_wdata[15:0]}}; end
      MEM_SW: be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DMEM_WORDS); i++) mem[i] <= '0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[widx][8*b +: 8] <= wd[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_rv32i_exec_units.sv
// Directed self-checking bench for the decoder, ALU and data memory.
module tb_rv32i_exec_units;
  import rv32i_defs::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst;
  logic [31:0] imm;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, alu_fn;
  logic [1:0]  rs1_sel, rs2_sel, wb_sel;
  logic [2:0]  br, mem_fn;
  logic        ecall;
  logic [4:0]  alu_op;
  logic [31:0] alu_src1, alu_src2, alu_out;
  logic [2:0]  dmem_fn;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  rv32i_exec_units #(.DMEM_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .inst(inst), .imm(imm),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .alu_fn(alu_fn),
    .rs1_sel(rs1_sel), .rs2_sel(rs2_sel), .br(br), .mem_fn(mem_fn), .wb_sel(wb_sel),
    .ecall(ecall), .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_out(alu_out), .dmem_fn(dmem_fn), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic check_dec(input string tag, input logic [31:0] i, input logic [31:0] e_imm,
                           input logic [4:0] e_rs1, input logic [4:0] e_rs2, input logic [4:0] e_rd,
                           input logic [4:0] e_fn, input logic [1:0] e_s1, input logic [1:0] e_s2,
                           input logic [2:0] e_br, input logic [2:0] e_mem, input logic [1:0] e_wb,
                           input logic e_ecall);
    inst = i;
    #1;
    check({tag, ".imm"},      imm,             e_imm);
    check({tag, ".rs1_addr"}, 32'(rs1_addr),   32'(e_rs1));
    check({tag, ".rs2_addr"}, 32'(rs2_addr),   32'(e_rs2));
    check({tag, ".rd_addr"},  32'(rd_addr),    32'(e_rd));
    check({tag, ".alu_fn"},   32'(alu_fn),     32'(e_fn));
    check({tag, ".rs1_sel"},  32'(rs1_sel),    32'(e_s1));
    check({tag, ".rs2_sel"},  32'(rs2_sel),    32'(e_s2));
    check({tag, ".br"},       32'(br),         32'(e_br));
    check({tag, ".mem_fn"},   32'(mem_fn),     32'(e_mem));
    check({tag, ".wb_sel"},   32'(wb_sel),     32'(e_wb));
    check({tag, ".ecall"},    32'(ecall),      32'(e_ecall));
  endtask

  task automatic check_alu(input string tag, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
    alu_op = op; alu_src1 = a; alu_src2 = b;
    #1;
    check(tag, alu_out, exp);
  endtask

  task automatic mem_store(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    dmem_fn = fn; dmem_addr = addr; dmem_wdata = data;
    @(posedge clk);
    #1;
    dmem_fn = MEM_LW;
  endtask

  task automatic mem_load(input string tag, input logic [2:0] fn, input logic [31:0] addr,
                          input logic [31:0] exp);
    dmem_fn = fn; dmem_addr = addr;
    #1;
    check(tag, dmem_rdata, exp);
  endtask

  initial begin
    reset = 1'b1; inst = '0; alu_op = '0; alu_src1 = '0; alu_src2 = '0;
    dmem_fn = MEM_LW; dmem_addr = '0; dmem_wdata = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Decoder
    check_dec("addi", 32'h00500093, 32'd5, 5'd0, 5'd0, 5'd1, ALU_ADD, RS1_RS1, RS2_IMI, BR_X, MEM_LW, WB_ALU, 1'b0);
    check_dec("jal",  32'h008000EF, 32'd8, 5'd0, 5'd0, 5'd1, ALU_ADD, RS1_PC, RS2_IMI, BR_JAL, MEM_LW, WB_PC, 1'b0);
    check_dec("zero", 32'h00000000, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0);
    check_dec("ecall", 32'h00000073, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b1);
    check_dec("ebreak", 32'h00100073, 32'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'd0, 2'd0, 3'd0, 3'd0, 2'd0, 1'b0);
    check_dec("sub",  32'h402081B3, 32'd0, 5'd1, 5'd2, 5'd3, ALU_SUB, RS1_RS1, RS2_RS2, BR_X, MEM_LW, WB_ALU, 1'b0);
    check_dec("srai", 32'h4030D093, 32'h403, 5'd1, 5'd0, 5'd1, ALU_SRA, RS1_RS1, RS2_IMI, BR_X, MEM_LW, WB_ALU, 1'b0);
    check_dec("sw",   32'h0020A223, 32'd4, 5'd1, 5'd2, 5'd0, ALU_ADD, RS1_RS1, RS2_IMI, BR_X, MEM_SW, WB_X, 1'b0);
    check_dec("bne",  32'hFE209EE3, 32'hFFFFFFFC, 5'd1, 5'd2, 5'd0, ALU_ADD, RS1_PC, RS2_IMI, BR_BNE, MEM_LW, WB_X, 1'b0);
    check_dec("lui",  32'h123452B7, 32'h12345000, 5'd0, 5'd0, 5'd5, ALU_ADD, RS1_X, RS2_IMI, BR_X, MEM_LW, WB_ALU, 1'b0);

    // ALU
    check_alu("alu_sub",   ALU_SUB,  32'd5, 32'd7, 32'hFFFFFFFE);
    check_alu("alu_sra",   ALU_SRA,  32'h80000000, 32'h24, 32'hF8000000);
    check_alu("alu_slt",   ALU_SLT,  32'hFFFFFFFF, 32'd1, 32'd1);
    check_alu("alu_sltu",  ALU_SLTU, 32'hFFFFFFFF, 32'd1, 32'd0);
    check_alu("alu_jalr",  ALU_JALR, 32'h101, 32'd2, 32'h102);
    check_alu("alu_wrap",  ALU_ADD,  32'hFFFFFFFF, 32'd1, 32'd0);
    check_alu("alu_srl",   ALU_SRL,  32'h80000000, 32'h24, 32'h08000000);
    check_alu("alu_undef", 5'd31,    32'h1234, 32'h5678, 32'd0);

    // Memory
    mem_load("mem_reset", MEM_LW, 32'h10, 32'h0);
    mem_store(MEM_SW, 32'h10, 32'h12345678);
    mem_load("lb_13",  MEM_LB,  32'h13, 32'h00000012);
    mem_load("lh_12",  MEM_LH,  32'h12, 32'h00001234);
    mem_load("lhu_10", MEM_LHU, 32'h10, 32'h00005678);
    mem_load("lh_13",  MEM_LH,  32'h13, 32'h00001234);
    mem_store(MEM_SB, 32'h11, 32'hFFFFFFAB);
    mem_load("lw_10",  MEM_LW,  32'h10, 32'h1234AB78);
    mem_load("lb_11",  MEM_LB,  32'h11, 32'hFFFFFFAB);
    mem_load("lbu_11", MEM_LBU, 32'h11, 32'h000000AB);
    mem_load("alias",  MEM_LW,  32'h1010, 32'h1234AB78);
    mem_store(MEM_SH, 32'h1012, 32'h0000BEEF);
    mem_load("sh_alias", MEM_LW, 32'h10, 32'hBEEFAB78);
    mem_load("lh_neg", MEM_LH,  32'h12, 32'hFFFFBEEF);
    mem_load("other_word", MEM_LW, 32'h14, 32'h0);

    // Reset wins over a simultaneous store
    @(negedge clk);
    reset = 1'b1; dmem_fn = MEM_SW; dmem_addr = 32'h10; dmem_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1 reset = 1'b0; dmem_fn = MEM_LW;
    mem_load("reset_store", MEM_LW, 32'h10, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
